// File: rtl/apb_completer.sv
// apb_completer -- APB4 completer backed by a byte-strobed word memory.
//
// One instance sits on each PSEL line at the leaf of the APB fabric. A
// transfer is captured in the setup cycle, decoded for alignment, range and
// protection, held for WAIT_STATES access cycles and then completed with
// PREADY=1 (and PSLVERR=1 when the decode was illegal).
//
// Ports:
//   PCLK, PRESETn        clock, asynchronous active-low reset
//   PSEL, PENABLE        select / access-phase indicator
//   PWRITE, PADDR        direction and byte address
//   PWDATA, PSTRB        write data and byte lane enables
//   PPROT                protection attributes (MSB=1 region needs 3'b111)
//   PRDATA               read data, loaded at the capture edge
//   PREADY, PSLVERR      completion / error, decoded from registered state

package apb_pkg;
  localparam int ADDR_WIDTH = 16;
  localparam int DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } state_t;
endpackage

module apb_completer #(
  parameter int ADDR_WIDTH  = apb_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH  = apb_pkg::DATA_WIDTH,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 1,
  localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [STRB_WIDTH-1:0] PSTRB,
  input  logic [2:0]            PPROT,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR
);
  localparam int ALIGNBITS = $clog2(STRB_WIDTH);
  localparam int IW        = $clog2(MEM_DEPTH);
  localparam int CW        = 4;

  // Captured transfer; legality is carried by the ACCESS/ERROR state itself.
  typedef struct packed {
    logic [IW-1:0]         idx;
    logic                  write;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] strb;
  } req_t;

  apb_pkg::state_t state, state_n;
  req_t            req;
  logic [CW-1:0]   cnt;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic          misalign, oor, prot_err, legal;
  logic [IW-1:0] cap_idx;
  logic          in_xfer, capture, complete, do_write;

  // ---------------------------------------------------------------- decode
  // The address MSB selects the upper half of the memory (the protected
  // region); the bits between the word index and the MSB must be zero.
  assign misalign = |PADDR[ALIGNBITS-1:0];
  assign prot_err = PADDR[ADDR_WIDTH-1] && (PPROT != 3'b111);

  generate
    if (IW > 1) begin : g_idx
      assign cap_idx = {PADDR[ADDR_WIDTH-1], PADDR[ALIGNBITS+IW-2:ALIGNBITS]};
    end else begin : g_idx1
      assign cap_idx = PADDR[ADDR_WIDTH-1];
    end
  endgenerate

  always_comb begin
    oor = 1'b0;
    for (int i = ALIGNBITS + IW - 1; i <= ADDR_WIDTH - 2; i++) oor = oor | PADDR[i];
  end

  assign legal = !(misalign || oor || prot_err);

  // ------------------------------------------------------------ handshakes
  assign in_xfer  = (state == apb_pkg::ACCESS) || (state == apb_pkg::ERROR);
  assign PREADY   = in_xfer && (cnt == CW'(WAIT_STATES));
  assign PSLVERR  = PREADY && (state == apb_pkg::ERROR);
  // SETUP is never entered; treating it like IDLE keeps a stray encoding safe.
  assign capture  = !in_xfer && PSEL && !PENABLE;
  assign complete = in_xfer && PSEL && PENABLE && PREADY;
  assign do_write = complete && (state == apb_pkg::ACCESS) && req.write;

  // ------------------------------------------------------------------ FSM
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state <= apb_pkg::IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      apb_pkg::ACCESS, apb_pkg::ERROR: begin
        // Dropping PSEL before completion aborts; PENABLE low just waits.
        if (!PSEL || complete) state_n = apb_pkg::IDLE;
      end
      default: begin
        if (capture) state_n = legal ? apb_pkg::ACCESS : apb_pkg::ERROR;
        else         state_n = apb_pkg::IDLE;
      end
    endcase
  end

  // ------------------------------------------------- capture and wait count
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      req <= '0;
      cnt <= '0;
    end else if (capture) begin
      req <= '{idx: cap_idx, write: PWRITE, wdata: PWDATA, strb: PSTRB};
      cnt <= '0;
    end else if (in_xfer && (cnt < CW'(WAIT_STATES))) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Read data is fetched at the capture edge so it is stable for the whole
  // access phase; errors clear it, legal writes leave it alone.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      PRDATA <= '0;
    end else if (capture) begin
      if (!legal)        PRDATA <= '0;
      else if (!PWRITE)  PRDATA <= mem[cap_idx];
    end
  end

  // -------------------------------------------------------------- memory
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    end else if (do_write) begin
      for (int b = 0; b < STRB_WIDTH; b++)
        if (req.strb[b]) mem[req.idx][8*b +: 8] <= req.wdata[8*b +: 8];
    end
  end

endmodule

// File: tb/tb_apb_completer.sv
// Self-checking bench for apb_completer. Three instances with WAIT_STATES of
// 1, 0 and 3 share the bus on separate PSEL lines; a word-array model per
// instance predicts read data, errors and transfer length.
module tb_apb_completer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  psel;
  logic        penable, pwrite;
  logic [15:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic [31:0] prdata_a [3];
  logic        pready_a [3];
  logic        pslverr_a [3];

  int errors = 0;
  int checks = 0;
  int ws [3] = '{1, 0, 3};

  logic [31:0] mdl_mem [3][256];
  logic [31:0] mdl_rd  [3];

  always #5 clk = ~clk;

  apb_completer #(.WAIT_STATES(1)) u_ws1 (
    .PCLK(clk), .PRESETn(rst_n), .PSEL(psel[0]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot),
    .PRDATA(prdata_a[0]), .PREADY(pready_a[0]), .PSLVERR(pslverr_a[0]));
  apb_completer #(.WAIT_STATES(0)) u_ws0 (
    .PCLK(clk), .PRESETn(rst_n), .PSEL(psel[1]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot),
    .PRDATA(prdata_a[1]), .PREADY(pready_a[1]), .PSLVERR(pslverr_a[1]));
  apb_completer #(.WAIT_STATES(3)) u_ws3 (
    .PCLK(clk), .PRESETn(rst_n), .PSEL(psel[2]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot),
    .PRDATA(prdata_a[2]), .PREADY(pready_a[2]), .PSLVERR(pslverr_a[2]));

  // ---------------------------------------------------------------- model
  // Legal: word aligned, low half below 128 words, upper half needs PPROT=7.
  function automatic bit m_legal(input logic [15:0] a, input logic [2:0] p);
    return (a % 4 == 0) && ((a & 16'h7FFF) < 16'd512) && (a < 16'h8000 || p == 3'd7);
  endfunction

  function automatic int m_idx(input logic [15:0] a);
    return (a >= 16'h8000 ? 128 : 0) + int'(a & 16'h01FF) / 4;
  endfunction

  task automatic m_apply(input int inst, input bit wr, input logic [15:0] a,
                         input logic [31:0] d, input logic [3:0] s, input logic [2:0] p);
    int k;
    if (!m_legal(a, p)) mdl_rd[inst] = 32'h0;
    else begin
      k = m_idx(a);
      if (wr) begin
        for (int b = 0; b < 4; b++)
          if (s[b]) mdl_mem[inst][k][8*b +: 8] = d[8*b +: 8];
      end else mdl_rd[inst] = mdl_mem[inst][k];
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 3; i++) begin
      mdl_rd[i] = 32'h0;
      for (int k = 0; k < 256; k++) mdl_mem[i][k] = 32'h0;
    end
  endtask

  // --------------------------------------------------------------- driver
  // Entered just after a rising edge; returns just after the completing edge
  // with the bus idle, so a following call issues its setup with no gap.
  // ok=0 when PREADY was high in setup, PSLVERR rose early, or PRDATA moved.
  task automatic xfer(input int inst, input bit wr, input logic [15:0] a,
                      input logic [31:0] d, input logic [3:0] s, input logic [2:0] p,
                      output logic [31:0] rd, output logic err, output int cyc,
                      output bit ok, output time t_done);
    logic [31:0] first_rd;
    bit seen;
    ok = 1; cyc = 1; seen = 0; rd = 32'h0; err = 1'b0; first_rd = 32'h0;
    psel = 3'b001 << inst; penable = 0; pwrite = wr; paddr = a;
    pwdata = d; pstrb = s; pprot = p;
    @(negedge clk);
    if (pready_a[inst] !== 1'b0) ok = 0;
    @(posedge clk); #1 penable = 1;
    while (1) begin
      cyc++;
      @(negedge clk);
      if (!seen) begin first_rd = prdata_a[inst]; seen = 1; end
      else if (prdata_a[inst] !== first_rd) ok = 0;
      if (pready_a[inst] === 1'b1) begin
        rd = prdata_a[inst]; err = pslverr_a[inst];
        break;
      end
      if (pslverr_a[inst] !== 1'b0) ok = 0;
      if (cyc > 40) break;
    end
    @(posedge clk); t_done = $time; #1;
    psel = 3'b000; penable = 0;
  endtask

  // ----------------------------------------------------------------- tests
  task automatic test_reset();
    rst_n = 0; psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0; pstrb = 0; pprot = 0;
    m_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks += 3;
      if (prdata_a[i] !== 32'h0) begin errors++; $display("FAIL reset_prdata[%0d]: got %h want 0", i, prdata_a[i]); end
      if (pready_a[i] !== 1'b0) begin errors++; $display("FAIL reset_pready[%0d]: got %b want 0", i, pready_a[i]); end
      if (pslverr_a[i] !== 1'b0) begin errors++; $display("FAIL reset_pslverr[%0d]: got %b want 0", i, pslverr_a[i]); end
    end
    @(posedge clk); #1 rst_n = 1;
    @(posedge clk); #1;
  endtask

  // Directed table on instance 0 (WAIT_STATES=1); each step is checked
  // against the model and, for the literal scenarios, against fixed values.
  task automatic test_directed();
    logic [15:0] ta [12] = '{16'h0010, 16'h0010, 16'h0020, 16'h0020, 16'h0020,
                             16'h0013, 16'h0800, 16'h0000, 16'h8004, 16'h8004,
                             16'h8004, 16'h0004};
    bit          tw [12] = '{1, 0, 1, 1, 0, 1, 0, 0, 1, 0, 1, 1};
    logic [31:0] td [12] = '{32'hDEADBEEF, 0, 32'h11223344, 32'hAABBCCDD, 0,
                             32'h55555555, 0, 0, 32'hA5A5A5A5, 0, 32'h5A5A5A5A, 32'h77777777};
    logic [3:0]  ts [12] = '{4'hF, 0, 4'hF, 4'b0101, 0, 4'hF, 0, 0, 4'hF, 0, 4'hF, 4'hF};
    logic [2:0]  tp [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 3'b111, 3'b111, 3'b010};
    logic [31:0] rd; logic err, exp_err; int cyc; bit ok; time t;
    for (int i = 0; i < 12; i++) begin
      xfer(0, tw[i], ta[i], td[i], ts[i], tp[i], rd, err, cyc, ok, t);
      exp_err = !m_legal(ta[i], tp[i]);
      m_apply(0, tw[i], ta[i], td[i], ts[i], tp[i]);
      checks += 4;
      if (err !== exp_err) begin errors++; $display("FAIL dir%0d_pslverr: got %b want %b", i, err, exp_err); end
      if (rd !== mdl_rd[0]) begin errors++; $display("FAIL dir%0d_prdata: got %h want %h", i, rd, mdl_rd[0]); end
      if (cyc != 3) begin errors++; $display("FAIL dir%0d_length: got %0d want 3", i, cyc); end
      if (!ok) begin errors++; $display("FAIL dir%0d_protocol: got 0 want 1", i); end
      case (i)
        1: begin checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_read: got %h want deadbeef", rd); end end
        4: begin checks++; if (rd !== 32'h11BB33DD) begin errors++; $display("FAIL strobe_read: got %h want 11bb33dd", rd); end end
        7: begin checks++; if (rd !== 32'h0) begin errors++; $display("FAIL err_mem_read: got %h want 0", rd); end end
        9: begin checks++; if (rd !== 32'h0) begin errors++; $display("FAIL pprot_blocked: got %h want 0", rd); end end
        default: ;
      endcase
      if (i == 11) begin
        // Read back the protected word after the low-region write.
        xfer(0, 0, 16'h8004, 0, 0, 3'b111, rd, err, cyc, ok, t);
        checks += 2;
        if (rd !== 32'h5A5A5A5A) begin errors++; $display("FAIL pprot_allowed: got %h want 5a5a5a5a", rd); end
        if (err !== 1'b0) begin errors++; $display("FAIL pprot_allowed_err: got %b want 0", err); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_abort();
    logic [31:0] rd; logic err; int cyc; bit ok; time t;
    xfer(2, 1, 16'h0040, 32'hCAFEF00D, 4'hF, 0, rd, err, cyc, ok, t);
    m_apply(2, 1, 16'h0040, 32'hCAFEF00D, 4'hF, 0);
    xfer(2, 0, 16'h0040, 0, 0, 0, rd, err, cyc, ok, t);
    m_apply(2, 0, 16'h0040, 0, 0, 0);
    checks++;
    if (rd !== 32'hCAFEF00D || cyc != 5) begin errors++; $display("FAIL abort_pre: got %h/%0d want cafef00d/5", rd, cyc); end
    // Start a write, then drop PSEL in the first wait cycle.
    psel = 3'b100; penable = 0; pwrite = 1; paddr = 16'h0040; pwdata = 32'h0BADBAD0; pstrb = 4'hF; pprot = 0;
    @(posedge clk); #1 penable = 1;
    @(posedge clk); #1 psel = 0; penable = 0;
    @(negedge clk);
    checks += 2;
    if (pready_a[2] !== 1'b0) begin errors++; $display("FAIL abort_pready: got %b want 0", pready_a[2]); end
    if (prdata_a[2] !== 32'hCAFEF00D) begin errors++; $display("FAIL abort_prdata: got %h want cafef00d", prdata_a[2]); end
    repeat (4) @(posedge clk);
    #1;
    xfer(2, 0, 16'h0040, 0, 0, 0, rd, err, cyc, ok, t);
    m_apply(2, 0, 16'h0040, 0, 0, 0);
    checks += 3;
    if (rd !== mdl_rd[2]) begin errors++; $display("FAIL abort_nowrite: got %h want %h", rd, mdl_rd[2]); end
    if (cyc != 5) begin errors++; $display("FAIL abort_idle_len: got %0d want 5", cyc); end
    if (!ok) begin errors++; $display("FAIL abort_protocol: got 0 want 1"); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd0, rd1; logic e0, e1; int c0, c1; bit ok0, ok1; time t0, t1;
    xfer(1, 1, 16'h0010, 32'h01020304, 4'hF, 0, rd0, e0, c0, ok0, t0);
    m_apply(1, 1, 16'h0010, 32'h01020304, 4'hF, 0);
    xfer(1, 0, 16'h0010, 0, 0, 0, rd0, e0, c0, ok0, t0);
    xfer(1, 0, 16'h0014, 0, 0, 0, rd1, e1, c1, ok1, t1);
    checks += 6;
    if (rd0 !== 32'h01020304) begin errors++; $display("FAIL b2b_rd0: got %h want 01020304", rd0); end
    if (rd1 !== 32'h0) begin errors++; $display("FAIL b2b_rd1: got %h want 0", rd1); end
    if (c0 != 2 || c1 != 2) begin errors++; $display("FAIL b2b_len: got %0d,%0d want 2,2", c0, c1); end
    if (t1 - t0 != 20) begin errors++; $display("FAIL b2b_gap: got %0t want 20", t1 - t0); end
    if (!ok0 || !ok1) begin errors++; $display("FAIL b2b_protocol: got %b%b want 11", ok0, ok1); end
    if (e0 !== 1'b0 || e1 !== 1'b0) begin errors++; $display("FAIL b2b_err: got %b%b want 00", e0, e1); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic err; int cyc; bit ok; time t;
    xfer(0, 1, 16'h0010, 32'hDEADBEEF, 4'hF, 0, rd, err, cyc, ok, t);
    xfer(0, 0, 16'h0010, 0, 0, 0, rd, err, cyc, ok, t);
    psel = 3'b001; penable = 0; pwrite = 1; paddr = 16'h0010; pwdata = 32'h12345678; pstrb = 4'hF; pprot = 0;
    @(posedge clk); #1 penable = 1;
    #2 rst_n = 0;
    #1;
    m_reset();
    checks += 3;
    if (prdata_a[0] !== 32'h0) begin errors++; $display("FAIL rstmid_prdata: got %h want 0", prdata_a[0]); end
    if (pready_a[0] !== 1'b0) begin errors++; $display("FAIL rstmid_pready: got %b want 0", pready_a[0]); end
    if (pslverr_a[0] !== 1'b0) begin errors++; $display("FAIL rstmid_pslverr: got %b want 0", pslverr_a[0]); end
    @(posedge clk); #1 psel = 0; penable = 0; rst_n = 1;
    @(posedge clk); #1;
    xfer(0, 0, 16'h0010, 0, 0, 0, rd, err, cyc, ok, t);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL rstmid_read: got %h want 0", rd); end
  endtask

  task automatic test_random();
    logic [31:0] rd, d; logic err, exp_err; int cyc, inst, kind; bit ok, wr; time t;
    logic [15:0] a; logic [3:0] s; logic [2:0] p;
    for (int n = 0; n < 80; n++) begin
      inst = $urandom % 3; wr = 1'($urandom % 2); kind = $urandom % 8;
      d = $urandom; s = 4'($urandom % 16); p = 3'($urandom % 8);
      case (kind)
        0, 1, 2, 3: a = 16'(($urandom % 16) * 4);
        4, 5: begin a = 16'h8000 | 16'(($urandom % 16) * 4); if ($urandom % 2) p = 3'b111; end
        6: a = 16'(($urandom % 16) * 4 + 1 + $urandom % 3);
        default: a = {1'($urandom % 2), 6'(1 + $urandom % 63), 7'($urandom), 2'b00};
      endcase
      xfer(inst, wr, a, d, s, p, rd, err, cyc, ok, t);
      exp_err = !m_legal(a, p);
      m_apply(inst, wr, a, d, s, p);
      checks += 3;
      if (err !== exp_err) begin errors++; $display("FAIL rnd%0d_pslverr: inst %0d addr %h got %b want %b", n, inst, a, err, exp_err); end
      if (rd !== mdl_rd[inst]) begin errors++; $display("FAIL rnd%0d_prdata: inst %0d addr %h got %h want %h", n, inst, a, rd, mdl_rd[inst]); end
      if (cyc != 2 + ws[inst] || !ok) begin errors++; $display("FAIL rnd%0d_timing: got len %0d ok %b want %0d ok 1", n, cyc, ok, 2 + ws[inst]); end
      if ($urandom % 2) begin @(posedge clk); #1; end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/apb_completer.md
# apb_completer

APB4 completer (peripheral side) that answers transfers issued by the team's APB requester, backed by a byte-strobed word memory. It decodes address alignment, range and the PPROT region map defined in `apb_pkg`. It inserts a programmable number of wait states and signals PSLVERR for illegal accesses. It sits at the leaf of the APB fabric, one instance per PSEL line.

## Interface

Parameters:
- ADDR_WIDTH, apb_pkg::ADDR_WIDTH (16), address bus width
- DATA_WIDTH, apb_pkg::DATA_WIDTH (32), data bus width; STRB_WIDTH = DATA_WIDTH/8
- MEM_DEPTH, 256, number of words; power of 2, at least 2
- WAIT_STATES, 1, number of PREADY-low ACCESS cycles per transfer (0–15)

Ports:
- PCLK, in, 1: clock; all state changes on the rising edge
- PRESETn, in, 1: reset, asynchronous, active-low
- PSEL, in, 1: completer select
- PENABLE, in, 1: access phase indicator
- PWRITE, in, 1: 1 = write, 0 = read
- PADDR, in, ADDR_WIDTH: byte address
- PWDATA, in, DATA_WIDTH: write data
- PSTRB, in, STRB_WIDTH: byte lane enables; PSTRB[n] covers PWDATA[8n+7:8n]
- PPROT, in, 3: protection attributes
- PRDATA, out, DATA_WIDTH: read data
- PREADY, out, 1: transfer complete
- PSLVERR, out, 1: transfer error, valid only while PREADY=1

## Operation

- FSM uses apb_pkg::state_t with three reachable states: IDLE, ACCESS and ERROR. SETUP is never entered; if seen, it is treated as IDLE.
- IDLE: at an edge with PSEL=1 and PENABLE=0, the block captures PADDR, PWRITE, PWDATA, PSTRB and PPROT and clears the wait counter.
  - If the decode is legal, next state is ACCESS; otherwise ERROR.
  - For a legal read, PRDATA <= mem[idx] at that same edge.
- Decode, with IW = log2(MEM_DEPTH):
  - Misaligned if PADDR[ALIGNBITS-1:0] != 0.
  - idx = {PADDR[ADDR_WIDTH-1], PADDR[ALIGNBITS+IW-2 : ALIGNBITS]}.
  - Out of range if any PADDR bit in [ADDR_WIDTH-2 : ALIGNBITS+IW-1] is nonzero.
  - Protection violation if PADDR[ADDR_WIDTH-1]=1 and PPROT != 3'b111. Addresses with MSB=0 accept any PPROT.
  - Any of these three conditions is illegal and selects ERROR.
- ACCESS/ERROR: the wait counter increments each cycle while it is below WAIT_STATES. PREADY = (state is ACCESS or ERROR) and counter == WAIT_STATES.
- Completion: an edge with PSEL=1, PENABLE=1 and PREADY=1 ends the transfer.
  - ACCESS write: for each n with the captured PSTRB[n]=1, byte n of mem[idx] <= byte n of the captured PWDATA.
  - Next state is IDLE.
- PSLVERR = PREADY and state == ERROR.
  - On an error, memory is not modified, and PRDATA is cleared to 0 at the capture edge.
- PRDATA:
  - Unchanged by legal writes.
  - Holds its value until the next captured transfer.
- Abort: if PSEL=0 in ACCESS or ERROR before completion, the block returns to IDLE with no write and leaves PRDATA unchanged.
- PENABLE=0 while in ACCESS or ERROR is ignored; the block waits.

## Timing

- Reset (PRESETn=0, asynchronous):
  - state = IDLE, counter = 0
  - PRDATA = 0, PREADY = 0, PSLVERR = 0
  - all memory words = 0
  - Takes effect mid-transfer as well; any in-flight write is discarded.
- PREADY and PSLVERR are combinational from registered state only; they have no combinational path from bus inputs.
- Transfer length:
  - Total length = 2 + WAIT_STATES cycles: 1 setup cycle, then WAIT_STATES cycles with PREADY=0, then 1 cycle with PREADY=1.
  - WAIT_STATES=0 gives PREADY=1 in the first access cycle.
- Back-to-back transfers: after completion the FSM is in IDLE. The requester's next SETUP cycle is captured at the following edge, with no dead cycle.
- Read data visibility: data written by a completed write is visible to a read whose setup cycle starts the next cycle.
- PRDATA is stable for the whole access phase.

## Test plan

- Write 0xDEADBEEF to 0x0010 with PSTRB=4'hF, WAIT_STATES=1, then read 0x0010:
  - PREADY high in the 3rd cycle of each transfer
  - PRDATA=0xDEADBEEF, PSLVERR=0
- Byte strobes: write 0x11223344 to 0x0020 with PSTRB=4'hF, then write 0xAABBCCDD with PSTRB=4'b0101, then read 0x0020:
  - read returns 0x11BB33DD
- Misaligned 0x0013 write, then out-of-range 0x0800 read (MEM_DEPTH=256), then read 0x0000:
  - first two transfers complete with PSLVERR=1 and PRDATA=0
  - memory unchanged; the 0x0000 read returns 0
- PPROT region, each access followed by a read of 0x8004:
  - write to 0x8004 with PPROT=3'b000: PSLVERR=1, read shows memory unchanged
  - same write with PPROT=3'b111: OK, read returns the data
  - write to 0x0004 with PPROT=3'b010: OK
- Abort and reset:
  - drop PSEL mid-access with WAIT_STATES=3: no write, FSM back in IDLE
  - assert PRESETn=0 during a write's access phase: outputs go to 0 immediately and a subsequent read returns 0
- Back-to-back: two reads with WAIT_STATES=0:
  - each completes in 2 cycles with no gap
  - PREADY is high only in the access cycles
